// File: rtl/sobel_bist_pkg.sv
// Shared types and constants for the Sobel BIST frame generator.
// Also holds the LFSR step function used by the pattern source.
package sobel_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_RAMP    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_LFSR    = 2'd2,
    MODE_FLAT    = 2'd3
  } mode_e;

  localparam logic [15:0] LFSR_RESEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps on bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS   = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sobel_bist_frame_gen_if.sv
// Pixel stream out to the Sobel core and result stream back from it.
interface sobel_bist_frame_gen_if #(
  parameter int unsigned PIX_W = 8
);
  logic [PIX_W-1:0] pix_o;
  logic             pix_valid_o;
  logic             pix_ready_i;
  logic             sof_o;
  logic             eol_o;
  logic             eof_o;
  logic [PIX_W-1:0] res_i;
  logic             res_valid_i;

  modport master (
    output pix_o, pix_valid_o, sof_o, eol_o, eof_o,
    input  pix_ready_i, res_i, res_valid_i
  );

  modport slave (
    input  pix_o, pix_valid_o, sof_o, eol_o, eof_o,
    output pix_ready_i, res_i, res_valid_i
  );
endinterface

// File: rtl/sobel_bist_misr.sv
// Multiple-input signature register compacting the returned result stream.
module sobel_bist_misr #(
  parameter int unsigned SIG_W    = 16,
  parameter int unsigned DIN_W    = 8,
  parameter logic [31:0] SIG_POLY = 32'h0000_1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);
  localparam logic [SIG_W-1:0] POLY = SIG_POLY[SIG_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(din);
    end
  end
endmodule

// File: rtl/sobel_bist_frame_gen.sv
// BIST source/sink: emits one patterned frame, then compacts returned results
// into a MISR signature until the expected count arrives or the drain times out.
module sobel_bist_frame_gen
  import sobel_bist_pkg::*;
#(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned SIG_W    = 16,
  parameter logic [31:0] SIG_POLY = 32'h0000_1021,
  parameter int unsigned TMO_W    = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [15:0]            seed_i,
  sobel_bist_frame_gen_if.master px,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [31:0]            res_count_o,
  output logic [SIG_W-1:0]       signature_o
);
  localparam int unsigned    XW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned    YW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H - 1);
  localparam logic [31:0]    FRAME_PIX = 32'(IMG_W * IMG_H);
  // One below all-ones: the increment from here is the saturating one
  localparam logic [TMO_W-1:0] TMO_PRE = ~TMO_W'(1);

  state_e           state;
  mode_e            mode_q;
  logic [PIX_W-1:0] flat_q;
  logic [15:0]      lfsr;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             pix_valid;
  logic [TMO_W-1:0] tmo;
  logic             timeout_q;
  logic [31:0]      res_count;
  logic [PIX_W-1:0] pattern;
  logic             start_ok, beat, at_eol, at_eof, res_take, chk_x, chk_y;

  assign start_ok = start_i && (state == ST_IDLE || state == ST_DONE);
  assign beat     = pix_valid && px.pix_ready_i;
  assign at_eol   = (x == X_LAST);
  assign at_eof   = at_eol && (y == Y_LAST);
  assign res_take = px.res_valid_i && (state == ST_RUN || state == ST_DRAIN);
  assign chk_x    = ((x >> 3) & XW'(1)) != '0;
  assign chk_y    = ((y >> 3) & YW'(1)) != '0;

  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_RAMP:    pattern = PIX_W'(x) + PIX_W'(y);
      MODE_CHECKER: pattern = (chk_x ^ chk_y) ? '1 : '0;
      MODE_LFSR:    pattern = lfsr[PIX_W-1:0];
      MODE_FLAT:    pattern = flat_q;
      default:      pattern = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_RAMP;
      flat_q    <= '0;
      lfsr      <= LFSR_RESEED;
      x         <= '0;
      y         <= '0;
      pix_valid <= 1'b0;
      tmo       <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state     <= ST_RUN;
            mode_q    <= mode_e'(mode_i);
            flat_q    <= seed_i[PIX_W-1:0];
            lfsr      <= (seed_i == 16'h0000) ? LFSR_RESEED : seed_i;
            x         <= '0;
            y         <= '0;
            pix_valid <= 1'b1;
            tmo       <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (beat) begin
            lfsr <= lfsr_step(lfsr);
            if (at_eol) begin
              x <= '0;
              if (at_eof) begin
                y         <= '0;
                pix_valid <= 1'b0;
                state     <= ST_DRAIN;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Count completion outranks a coincident timeout
          if (res_count >= FRAME_PIX) begin
            state <= ST_DONE;
          end else if (px.res_valid_i) begin
            tmo <= '0;
          end else if (tmo == TMO_PRE) begin
            tmo       <= '1;
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count <= '0;
    end else if (start_ok) begin
      res_count <= '0;
    end else if (res_take && res_count != '1) begin
      res_count <= res_count + 32'd1;
    end
  end

  sobel_bist_misr #(
    .SIG_W    (SIG_W),
    .DIN_W    (PIX_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (res_take),
    .clr   (start_ok),
    .din   (px.res_i),
    .sig   (signature_o)
  );

  assign px.pix_o       = pix_valid ? pattern : '0;
  assign px.pix_valid_o = pix_valid;
  assign px.sof_o       = pix_valid && (x == '0) && (y == '0);
  assign px.eol_o       = pix_valid && at_eol;
  assign px.eof_o       = pix_valid && at_eof;
  assign busy_o         = (state == ST_RUN) || (state == ST_DRAIN);
  assign done_o         = (state == ST_DONE);
  assign timeout_o      = timeout_q;
  assign res_count_o    = res_count;
endmodule

// File: tb/tb_sobel_bist_frame_gen.sv
// Scoreboard bench for sobel_bist_frame_gen on a 4x2 frame with a 4-bit drain timeout.
module tb_sobel_bist_frame_gen;
  localparam int W = 4;
  localparam int H = 2;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  typedef struct {
    int unsigned cnt;
    logic        tmo;
    logic [15:0] sig;
  } status_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [15:0] seed_i;
  logic        busy_o, done_o, timeout_o;
  logic [31:0] res_count_o;
  logic [15:0] signature_o;

  sobel_bist_frame_gen_if #(.PIX_W(8)) px ();

  sobel_bist_frame_gen #(
    .IMG_W    (W),
    .IMG_H    (H),
    .PIX_W    (8),
    .SIG_W    (16),
    .SIG_POLY (32'h0000_1021),
    .TMO_W    (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .seed_i      (seed_i),
    .px          (px),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .res_count_o (res_count_o),
    .signature_o (signature_o)
  );

  always #5 clk = ~clk;

  beat_t   pix_q[$];
  status_t stat_q[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      beat_cnt = 0;
  int      done_cnt = 0;
  int      eof_edge = 0;
  int      done_edge = 0;
  int      rdy_mode = 0;
  logic    loop_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: 0 always ready, 1 alternate, 2 random
  initial begin
    px.pix_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       px.pix_ready_i = 1'b1;
        1:       px.pix_ready_i = ~px.pix_ready_i;
        default: px.pix_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Core stand-in: returns each accepted pixel three cycles later
  initial begin
    logic [8:0] dl[$];
    logic [8:0] cur;
    logic       b;
    logic [7:0] d;
    px.res_valid_i = 1'b0;
    px.res_i       = '0;
    forever begin
      @(negedge clk);
      b = px.pix_valid_o & px.pix_ready_i & loop_en;
      d = px.pix_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        dl.delete();
        px.res_valid_i = 1'b0;
        px.res_i       = '0;
      end else begin
        dl.push_back({b, d});
        if (dl.size() > 3) begin
          cur = dl.pop_front();
          px.res_valid_i = cur[8];
          px.res_i       = cur[7:0];
        end else begin
          px.res_valid_i = 1'b0;
        end
      end
    end
  end

  // Pixel monitor: pops expected beats, checks hold during stalls
  initial begin
    logic  stall_prev;
    beat_t held, e;
    stall_prev = 1'b0;
    held = '{pix: 8'd0, sof: 1'b0, eol: 1'b0, eof: 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!(px.pix_valid_o && px.pix_o == held.pix && px.sof_o == held.sof &&
                px.eol_o == held.eol && px.eof_o == held.eof)) begin
            failures++;
            $display("FAIL stall_hold: got v=%0b pix=%02h sof=%0b eol=%0b eof=%0b expected v=1 pix=%02h sof=%0b eol=%0b eof=%0b",
                     px.pix_valid_o, px.pix_o, px.sof_o, px.eol_o, px.eof_o, held.pix, held.sof, held.eol, held.eof);
          end
        end
        if (px.pix_valid_o && px.pix_ready_i) begin
          checks++;
          beat_cnt++;
          if (px.eof_o) eof_edge = cyc + 1;
          if (pix_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected: got pix=%02h expected no beat", px.pix_o);
          end else begin
            e = pix_q.pop_front();
            if (px.pix_o != e.pix || px.sof_o != e.sof || px.eol_o != e.eol || px.eof_o != e.eof) begin
              failures++;
              $display("FAIL beat: got pix=%02h sof=%0b eol=%0b eof=%0b expected pix=%02h sof=%0b eol=%0b eof=%0b",
                       px.pix_o, px.sof_o, px.eol_o, px.eof_o, e.pix, e.sof, e.eol, e.eof);
            end
          end
        end
        stall_prev = px.pix_valid_o & ~px.pix_ready_i;
        held = '{pix: px.pix_o, sof: px.sof_o, eol: px.eol_o, eof: px.eof_o};
      end
    end
  end

  // Status monitor: on each rising done_o compare the final frame status
  initial begin
    logic    done_prev;
    status_t s;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_o && !done_prev) begin
        done_edge = cyc;
        done_cnt++;
        checks++;
        if (stat_q.size() == 0) begin
          failures++;
          $display("FAIL done_unexpected: got done=1 expected no completion");
        end else begin
          s = stat_q.pop_front();
          if (res_count_o != s.cnt || timeout_o != s.tmo || signature_o != s.sig) begin
            failures++;
            $display("FAIL status: got count=%0d tmo=%0b sig=%04h expected count=%0d tmo=%0b sig=%04h",
                     res_count_o, timeout_o, signature_o, s.cnt, s.tmo, s.sig);
          end
        end
        checks++;
        if (pix_q.size() != 0) begin
          failures++;
          $display("FAIL beats_missing: got %0d beats outstanding expected 0", pix_q.size());
        end
      end
      done_prev = done_o;
    end
  end

  // Reference model: frame contents from the pattern rules, MISR over returned values
  task automatic push_frame(input int m, input logic [15:0] seed, input logic lp);
    logic [15:0] lf, sig;
    logic        fb;
    int          p;
    beat_t       b;
    lf  = (seed == 16'h0000) ? 16'hACE1 : seed;
    sig = 16'h0000;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        case (m)
          0:       p = (xx + yy) % 256;
          1:       p = (((xx >> 3) ^ (yy >> 3)) & 1) ? 255 : 0;
          2:       p = int'(lf & 16'h00FF);
          default: p = int'(seed & 16'h00FF);
        endcase
        b.pix = 8'(p);
        b.sof = (xx == 0 && yy == 0);
        b.eol = (xx == W - 1);
        b.eof = (xx == W - 1 && yy == H - 1);
        pix_q.push_back(b);
        if (lp) sig = ((sig << 1) ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, b.pix};
        fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
        lf = {fb, lf[15:1]};
      end
    end
    stat_q.push_back('{cnt: lp ? W * H : 0, tmo: ~lp, sig: lp ? sig : 16'h0000});
  endtask

  task automatic run_frame(input int m, input logic [15:0] seed, input int rm,
                           input logic lp, input logic mid_start);
    int target;
    int n;
    rdy_mode = rm;
    loop_en  = lp;
    push_frame(m, seed, lp);
    target = done_cnt + 1;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    mode_i  = 2'(m);
    seed_i  = seed;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    mode_i  = 2'(~m);
    seed_i  = 16'($urandom);
    if (mid_start) begin
      repeat (3) @(posedge clk);
      #1;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL done_wait: got no done_o within 400 cycles expected done_o");
      pix_q.delete();
      stat_q.delete();
    end else if (!lp) begin
      checks++;
      if (done_edge - eof_edge != 15) begin
        failures++;
        $display("FAIL drain_timeout_cycles: got %0d expected 15", done_edge - eof_edge);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_quiet(input string tag);
    checks++;
    if (px.pix_o != 8'h00 || px.pix_valid_o || px.sof_o || px.eol_o || px.eof_o ||
        busy_o || done_o || timeout_o || res_count_o != 32'd0 || signature_o != 16'h0000) begin
      failures++;
      $display("FAIL %s: got pix=%02h v=%0b sof=%0b eol=%0b eof=%0b busy=%0b done=%0b tmo=%0b cnt=%0d sig=%04h expected all zero",
               tag, px.pix_o, px.pix_valid_o, px.sof_o, px.eol_o, px.eof_o,
               busy_o, done_o, timeout_o, res_count_o, signature_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n   = 1'b0;
    start_i = 1'b0;
    mode_i  = 2'd0;
    seed_i  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle_after_reset");

    run_frame(0, 16'h0000, 0, 1'b1, 1'b0);  // ramp, always ready
    run_frame(0, 16'h1234, 1, 1'b1, 1'b0);  // ramp, ready toggling
    run_frame(0, 16'h0000, 0, 1'b0, 1'b0);  // no results: drain timeout
    run_frame(2, 16'h0000, 0, 1'b1, 1'b0);  // LFSR seed 0 reseeds
    run_frame(2, 16'h0001, 1, 1'b1, 1'b0);  // LFSR seed 1
    run_frame(1, 16'h5555, 2, 1'b1, 1'b0);  // checker
    run_frame(3, 16'hBEA7, 2, 1'b1, 1'b1);  // flat, start pulsed mid-frame
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(0, 3)), 16'($urandom), 2,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    // Reset mid-frame, then a fresh ramp frame must start from pix 0
    rdy_mode = 0;
    loop_en  = 1'b1;
    push_frame(0, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    mode_i  = 2'd0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    t = beat_cnt + 5;
    for (int n = 0; n < 100 && beat_cnt < t; n++) @(negedge clk);
    checks++;
    if (beat_cnt < t) begin
      failures++;
      $display("FAIL reset_setup: got %0d beats expected %0d", beat_cnt, t);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pix_q.delete();
    stat_q.delete();
    @(negedge clk);
    check_quiet("reset_mid_frame");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("idle_after_mid_reset");
    run_frame(0, 16'h0000, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
